// File: rtl/sd_buf_pkg.sv
// Shared types and constants for the SD buffer RAM arbiter (sd_buf_arbiter).
package sd_buf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2,
    OWN   = 2'd3
  } sd_arb_state_e;

  localparam int SD_BUF_AW      = 10;
  localparam int SD_BUF_WIN_LSB = 12;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  // On a tie the master that did not hold the port last time wins.
  function automatic logic [1:0] rrPick(input logic [1:0] req, input logic lastM1);
    logic [1:0] pick;
    if (req == 2'b11) begin
      pick = lastM1 ? GRANT_M0 : GRANT_M1;
    end else begin
      pick = req;
    end
    return pick;
  endfunction

endpackage

// File: rtl/sd_rr_arb2.sv
// Two-input grant picker with last-owner history for sd_buf_arbiter.
// SD_ARB_FIXED_PRIO_EN selects fixed priority (m0 first) instead of round-robin.
module sd_rr_arb2
  import sd_buf_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       updM1_i,
  output logic [1:0] pick_o
);

  logic lastM1_q;

  // Records who owned the port when the grant is released; m1 after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lastM1_q <= 1'b1;
    end else if (update_i) begin
      lastM1_q <= updM1_i;
    end
  end

`ifdef SD_ARB_FIXED_PRIO_EN
  logic unusedLastM1;
  assign unusedLastM1 = lastM1_q;
  assign pick_o       = req_i[0] ? GRANT_M0 : {req_i[1], 1'b0};
`else
  assign pick_o = rrPick(req_i, lastM1_q);
`endif

endmodule

// File: rtl/sd_buf_arbiter.sv
// Shares port B of the 1024x32 SD buffer RAM between two Wishbone-classic masters.
// Define SD_ARB_FIXED_PRIO_EN for fixed m0 priority with an uncapped m0 burst.
module sd_buf_arbiter
  import sd_buf_pkg::*;
#(
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned WIN_HI    = 31
) (
  input  logic                 clkCPU,
  input  logic                 globlRst,
  input  logic                 m0_cyc,
  input  logic                 m1_cyc,
  input  logic                 m0_stb,
  input  logic                 m1_stb,
  input  logic                 m0_we,
  input  logic                 m1_we,
  input  logic [3:0]           m0_sel,
  input  logic [3:0]           m1_sel,
  input  logic [31:0]          m0_adr,
  input  logic [31:0]          m1_adr,
  input  logic [31:0]          m0_dat_i,
  input  logic [31:0]          m1_dat_i,
  output logic [31:0]          m0_dat_o,
  output logic [31:0]          m1_dat_o,
  output logic                 m0_ack,
  output logic                 m1_ack,
  output logic                 m0_err,
  output logic                 m1_err,
  output logic                 buf_en,
  output logic [3:0]           buf_we,
  output logic [SD_BUF_AW-1:0] buf_addr,
  output logic [31:0]          buf_din,
  input  logic [31:0]          buf_dout,
  output logic [1:0]           grant
);

  localparam logic [7:0] MaxBurstC = 8'(MAX_BURST);

  sd_arb_state_e state_q;
  logic [1:0]    grant_q;
  logic [1:0]    ack_q;
  logic [1:0]    err_q;
  logic [7:0]    count_q;
  logic [31:0]   rdHold0_q;
  logic [31:0]   rdHold1_q;

  logic [1:0]    pick;
  logic          ownCyc;
  logic          ownStb;
  logic          ownWe;
  logic [3:0]    ownSel;
  logic [31:0]   ownAdr;
  logic [31:0]   ownDat;
  logic          inWindow;
  logic          capAllows;
  logic          relGrant;
  logic          unusedAdr;

  always_comb begin
    if (grant_q[1]) begin
      ownCyc = m1_cyc;
      ownStb = m1_stb;
      ownWe  = m1_we;
      ownSel = m1_sel;
      ownAdr = m1_adr;
      ownDat = m1_dat_i;
    end else begin
      ownCyc = m0_cyc;
      ownStb = m0_stb;
      ownWe  = m0_we;
      ownSel = m0_sel;
      ownAdr = m0_adr;
      ownDat = m0_dat_i;
    end
  end

  assign inWindow  = (ownAdr[WIN_HI:SD_BUF_WIN_LSB] == '0);
  assign unusedAdr = ^ownAdr[1:0];

`ifdef SD_ARB_FIXED_PRIO_EN
  assign capAllows = grant_q[0] || (count_q < MaxBurstC);
`else
  assign capAllows = (count_q < MaxBurstC);
`endif

  // The grant is given up either at the burst cap or when the owner drops cyc.
  assign relGrant = ((state_q == ACK) && !(ownCyc && capAllows)) ||
                    ((state_q == OWN) && !ownCyc);

  sd_rr_arb2 u_arb (
    .clk_i    (clkCPU),
    .rst_ni   (globlRst),
    .req_i    ({m1_cyc & m1_stb, m0_cyc & m0_stb}),
    .update_i (relGrant),
    .updM1_i  (grant_q[1]),
    .pick_o   (pick)
  );

  always_ff @(posedge clkCPU or negedge globlRst) begin
    if (!globlRst) begin
      state_q <= IDLE;
      grant_q <= GRANT_NONE;
      count_q <= '0;
      ack_q   <= 2'b00;
      err_q   <= 2'b00;
    end else begin
      ack_q <= 2'b00;
      err_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (pick != GRANT_NONE) begin
            grant_q <= pick;
            count_q <= '0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (inWindow) begin
            ack_q <= grant_q;
          end else begin
            err_q <= grant_q;
          end
          count_q <= count_q + 8'd1;
          state_q <= ACK;
        end
        ACK: begin
          if (ownCyc && capAllows) begin
            state_q <= OWN;
          end else begin
            state_q <= IDLE;
            grant_q <= GRANT_NONE;
          end
        end
        OWN: begin
          if (!ownCyc) begin
            state_q <= IDLE;
            grant_q <= GRANT_NONE;
          end else if (ownStb) begin
            state_q <= ISSUE;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= GRANT_NONE;
        end
      endcase
    end
  end

  // Read data stays visible after the ack so a slow master can still pick it up.
  always_ff @(posedge clkCPU or negedge globlRst) begin
    if (!globlRst) begin
      rdHold0_q <= '0;
      rdHold1_q <= '0;
    end else begin
      if (ack_q[0] && !m0_we) begin
        rdHold0_q <= buf_dout;
      end
      if (ack_q[1] && !m1_we) begin
        rdHold1_q <= buf_dout;
      end
    end
  end

  assign buf_en   = (state_q == ISSUE) && inWindow;
  assign buf_we   = (buf_en && ownWe) ? ownSel : 4'h0;
  assign buf_addr = ownAdr[SD_BUF_AW+1:2];
  assign buf_din  = ownDat;

  assign m0_ack   = ack_q[0];
  assign m1_ack   = ack_q[1];
  assign m0_err   = err_q[0];
  assign m1_err   = err_q[1];
  assign m0_dat_o = ack_q[0] ? buf_dout : rdHold0_q;
  assign m1_dat_o = ack_q[1] ? buf_dout : rdHold1_q;
  assign grant    = grant_q;

endmodule

// File: tb/tb_sd_buf_arbiter.sv
// Directed self-checking bench for sd_buf_arbiter with a behavioural 1024x32 RAM.
module tb_sd_buf_arbiter;

  logic        clkCPU = 1'b0;
  logic        globlRst;
  logic        m0_cyc, m1_cyc, m0_stb, m1_stb, m0_we, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_adr, m1_adr, m0_dat_i, m1_dat_i;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic        buf_en;
  logic [3:0]  buf_we;
  logic [9:0]  buf_addr;
  logic [31:0] buf_din;
  logic [31:0] buf_dout;
  logic [1:0]  grant;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [1024];
  bit          ramReady = 1'b0;

  sd_buf_arbiter #(.MAX_BURST(16), .WIN_HI(31)) dut (
    .clkCPU(clkCPU), .globlRst(globlRst),
    .m0_cyc(m0_cyc), .m1_cyc(m1_cyc), .m0_stb(m0_stb), .m1_stb(m1_stb),
    .m0_we(m0_we), .m1_we(m1_we), .m0_sel(m0_sel), .m1_sel(m1_sel),
    .m0_adr(m0_adr), .m1_adr(m1_adr), .m0_dat_i(m0_dat_i), .m1_dat_i(m1_dat_i),
    .m0_dat_o(m0_dat_o), .m1_dat_o(m1_dat_o), .m0_ack(m0_ack), .m1_ack(m1_ack),
    .m0_err(m0_err), .m1_err(m1_err), .buf_en(buf_en), .buf_we(buf_we),
    .buf_addr(buf_addr), .buf_din(buf_din), .buf_dout(buf_dout), .grant(grant)
  );

  always #5 clkCPU = ~clkCPU;

  // Synchronous read-first RAM; word i preloaded with 0x5A5A0000 | i.
  always @(posedge clkCPU) begin
    if (!ramReady) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h5A5A_0000 | i;
      buf_dout <= '0;
      ramReady <= 1'b1;
    end else if (buf_en) begin
      buf_dout <= mem[buf_addr];
      for (int b = 0; b < 4; b++)
        if (buf_we[b]) mem[buf_addr][8*b +: 8] <= buf_din[8*b +: 8];
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int m, input logic cyc, input logic stb, input logic we,
                               input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    if (m == 0) begin
      m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_dat_i = dat; m0_sel = sel;
    end else begin
      m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_dat_i = dat; m1_sel = sel;
    end
  endtask

  task automatic dropMaster(input int m);
    applyStimulus(m, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic doReset();
    globlRst = 1'b0;
    dropMaster(0);
    dropMaster(1);
    repeat (2) @(negedge clkCPU);
    globlRst = 1'b1;
  endtask

  // Waits (bounded) for the master's ack/err, releases the master, then idles one cycle.
  task automatic finishAccess(input int m, output bit got, output bit sawErr, output logic [31:0] rd);
    got = 1'b0; sawErr = 1'b0; rd = '0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clkCPU);
      if (m == 0 && (m0_ack || m0_err)) begin
        got = 1'b1; sawErr = m0_err; rd = m0_dat_o; dropMaster(0);
      end else if (m == 1 && (m1_ack || m1_err)) begin
        got = 1'b1; sawErr = m1_err; rd = m1_dat_o; dropMaster(1);
      end
    end
    @(negedge clkCPU);
  endtask

  task automatic doAccess(input int m, input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel,
                          output bit got, output bit sawErr, output logic [31:0] rd);
    applyStimulus(m, 1'b1, 1'b1, we, adr, dat, sel);
    finishAccess(m, got, sawErr, rd);
  endtask

  initial begin
    bit          got, sawErr;
    logic [31:0] rd;
    int          m1Acks, m0Acks, m1BeforeM0, errCount, ackCount, errAt;
    bit          enSeen, m1Done;
    logic [31:0] m1Last, m0Seen;

    globlRst = 1'b0;
    dropMaster(0);
    dropMaster(1);
    repeat (2) @(negedge clkCPU);
    checkOutput("reset ack/err/en", {m0_ack, m1_ack, m0_err, m1_err, buf_en}, 32'h0);
    checkOutput("reset buf_we", buf_we, 32'h0);
    checkOutput("reset grant", grant, 32'h0);
    globlRst = 1'b1;
    @(negedge clkCPU);
    checkOutput("idle grant", grant, 32'h0);

    $display("[TB] m0 write then read at 0x10");
    applyStimulus(0, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'hA1B2_C3D4, 4'hF);
    @(negedge clkCPU);
    checkOutput("wr c1 grant", grant, 32'h1);
    checkOutput("wr c1 buf_en", buf_en, 32'h1);
    checkOutput("wr c1 buf_addr", buf_addr, 32'h004);
    checkOutput("wr c1 buf_we", buf_we, 32'hF);
    checkOutput("wr c1 buf_din", buf_din, 32'hA1B2_C3D4);
    checkOutput("wr c1 no ack yet", m0_ack, 32'h0);
    @(negedge clkCPU);
    checkOutput("wr c2 ack/err", {m0_ack, m0_err}, 32'h2);
    dropMaster(0);
    @(negedge clkCPU);
    checkOutput("wr ack one cycle", m0_ack, 32'h0);
    checkOutput("wr grant released", grant, 32'h0);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
    @(negedge clkCPU);
    checkOutput("rd c1 buf_en/we", {buf_en, buf_we}, 32'h10);
    @(negedge clkCPU);
    checkOutput("rd c2 ack", m0_ack, 32'h1);
    checkOutput("rd c2 data", m0_dat_o, 32'hA1B2_C3D4);
    dropMaster(0);
    @(negedge clkCPU);
    checkOutput("rd data held", m0_dat_o, 32'hA1B2_C3D4);

    $display("[TB] simultaneous requests after reset");
    doReset();
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'hF);
    @(negedge clkCPU);
    checkOutput("tie1 grant m0", grant, 32'h1);
    @(negedge clkCPU);
    checkOutput("tie1 acks", {m0_ack, m1_ack}, 32'h2);
    checkOutput("tie1 m0 data", m0_dat_o, 32'hA1B2_C3D4);
    dropMaster(0);
    @(negedge clkCPU);
    checkOutput("tie1 release", grant, 32'h0);
    @(negedge clkCPU);
    checkOutput("tie1 then m1", grant, 32'h2);
    checkOutput("tie1 m1 addr", buf_addr, 32'h008);
    @(negedge clkCPU);
    checkOutput("tie1 m1 acks", {m0_ack, m1_ack}, 32'h1);
    checkOutput("tie1 m1 data", m1_dat_o, 32'h5A5A_0008);
    dropMaster(1);
    @(negedge clkCPU);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'hF);
    @(negedge clkCPU);
    checkOutput("tie2 grant m0", grant, 32'h1);
    finishAccess(0, got, sawErr, rd);
    checkOutput("tie2 m0 done", got, 32'h1);
    finishAccess(1, got, sawErr, rd);
    checkOutput("tie2 m1 done", got, 32'h1);
    checkOutput("tie2 m1 data", rd, 32'h5A5A_0008);

    $display("[TB] out-of-window access from m1");
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
    errCount = 0; ackCount = 0; errAt = 0; enSeen = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clkCPU);
      if (buf_en) enSeen = 1'b1;
      if (m1_ack) ackCount++;
      if (m1_err) begin errCount++; errAt = k; end
      if (m1_ack || m1_err) dropMaster(1);
    end
    checkOutput("err count", errCount, 32'd1);
    checkOutput("err cycle", errAt, 32'd2);
    checkOutput("err no ack", ackCount, 32'd0);
    checkOutput("err no buf_en", enSeen, 32'd0);

    $display("[TB] m1 burst of 20 against the cap with m0 waiting");
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'hF);
    m1Acks = 0; m0Acks = 0; m1BeforeM0 = -1; m1Done = 1'b0;
    m1Last = '0; m0Seen = '0;
    for (int k = 0; k < 300 && !(m1Done && m0Acks > 0); k++) begin
      @(negedge clkCPU);
      if (m1_ack) begin
        m1Acks++;
        m1Last = m1_dat_o;
        if (m1Acks == 1) applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
        if (m1Acks == 20) begin dropMaster(1); m1Done = 1'b1; end
      end
      if (m0_ack) begin
        m0Acks++;
        m1BeforeM0 = m1Acks;
        m0Seen = m0_dat_o;
        dropMaster(0);
      end
    end
    @(negedge clkCPU);
    checkOutput("burst m1 acks before m0", m1BeforeM0, 32'd16);
    checkOutput("burst m1 total", m1Acks, 32'd20);
    checkOutput("burst m0 acks", m0Acks, 32'd1);
    checkOutput("burst m1 data", m1Last, 32'h5A5A_0010);
    checkOutput("burst m0 data", m0Seen, 32'hA1B2_C3D4);
    checkOutput("burst end idle", grant, 32'h0);

    $display("[TB] partial byte-lane write");
    doAccess(0, 1'b1, 32'h0000_0080, 32'hFFFF_FFFF, 4'hF, got, sawErr, rd);
    checkOutput("sel fill done", {got, sawErr}, 32'h2);
    doAccess(0, 1'b1, 32'h0000_0080, 32'h1234_5678, 4'b0011, got, sawErr, rd);
    checkOutput("sel partial done", {got, sawErr}, 32'h2);
    doAccess(0, 1'b0, 32'h0000_0080, 32'h0, 4'hF, got, sawErr, rd);
    checkOutput("sel readback", rd, 32'hFFFF_5678);

    $display("[TB] reset during ISSUE");
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 4'hF);
    @(negedge clkCPU);
    checkOutput("rst issue buf_en", buf_en, 32'h1);
    globlRst = 1'b0;
    dropMaster(0);
    @(negedge clkCPU);
    checkOutput("rst abort ack/err", {m0_ack, m0_err, m1_ack, m1_err}, 32'h0);
    checkOutput("rst abort grant", grant, 32'h0);
    checkOutput("rst abort buf_en", buf_en, 32'h0);
    globlRst = 1'b1;
    @(negedge clkCPU);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
